key_disp_buf: RTL and testbench
===============================

// Module: key_disp_buf
// PURPOSE
//  Captures 4-bit key codes from the 4x4 keypad scanner (key_num/key_valid pulse) into a DIGITS-deep entry buffer.
//  Drives a time-multiplexed, active-low 7-segment display showing the entered digits. Newest digit is on the right, at digit 0.
//  Sits directly downstream of the keypad scanner and directly upstream of the board display pins.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  SCAN_HZ  1_000       per-digit refresh rate; SCAN_DIV = CLK_HZ/SCAN_HZ; one scan tick per SCAN_DIV clocks
//  DIGITS   4           number of display digits / buffer entries, legal range 2..8
// PORTS
//  clk        in   1                       system clock, rising edge
//  rst_n      in   1                       asynchronous reset, active-low
//  key_num    in   4                       key code from the scanner; valid only while key_valid=1
//  key_valid  in   1                       one-cycle strobe, one per key press
//  clr        in   1                       synchronous clear of the buffer, active-high
//  sel        out  DIGITS                  digit enables, active-low one-hot
//  seg        out  8                       {dp,g,f,e,d,c,b,a}, active-low
//  count      out  $clog2(DIGITS+1)        number of digits entered, 0..DIGITS
//  full       out  1                       1 when count==DIGITS
// BEHAVIOUR
//  Reset values: buffer entries=0, count=0, scan idx=0, prescaler=0, sel=~1 (digit 0 enabled), seg=8'hFF (blank), full=0.
//  Entry, when key_valid=1 and clr=0:
//   buf <= {buf[DIGITS-2:0], key_num}
//   count <= min(count+1, DIGITS)
//   When full, the oldest digit is dropped and count stays at DIGITS.
//  clr=1 clears buf and count to 0 in the next cycle. When clr and key_valid are high in the same cycle, clr wins and the key is lost.
//  Prescaler counts 0..SCAN_DIV-1 and wraps. At the wrap cycle (tick), idx <= (idx==DIGITS-1) ? 0 : idx+1.
//  sel and seg are registered every cycle from the current idx/buf:
//   sel <= ~(1<<idx)
//   seg <= (idx<count) ? hex2seg(buf[idx]) : 8'hFF
//   sel and seg always change in the same cycle.
//  Latency: a key strobe at cycle N updates buf/count at N+1. seg reflects it at N+2 if idx points at that digit.
//  Unentered digits (idx>=count) are blanked; no leading zeros are shown.
//  Encoding, dp off:
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//   8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//  Strobes arriving back-to-back on consecutive cycles are each accepted; there is no back-pressure.
//  Asserting rst_n mid-scan or mid-entry returns all state to its reset values asynchronously.
// CONFIGURATION
//  KEY_DISP_EDIT_EN defined:
//   key 4'hF is backspace: buf <= {0, buf[DIGITS-1:1]}, count <= max(count-1, 0); nothing is inserted.
//   key 4'hE acts as clr.
//   Backspace at count=0 and E at count=0 leave state unchanged.
//  KEY_DISP_EDIT_EN undefined: all 16 codes are entered as digits.
// STRUCTURE
//  Package key_disp_pkg holds:
//   SEG_BLANK=8'hFF
//   KEY_BKSP=4'hF
//   KEY_CLR=4'hE
//   function hex2seg(input [3:0]) returning [7:0]
//  One sub-module, scan_tick_gen (params CLK_HZ, SCAN_HZ; ports clk, rst_n, tick), produces the one-cycle tick.
//  Buffer, count and display mux remain in key_disp_buf.
// TESTING  (bench uses CLK_HZ=1000, SCAN_HZ=100 -> SCAN_DIV=10, DIGITS=4)
//  1. Reset, no keys -> seg=8'hFF for every idx; sel cycles E,D,B,7 with a new value every 10 clocks; count=0.
//  2. Keys 1,2,3 -> count=3, full=0; digit0 seg=B0, digit1=A4, digit2=F9, digit3=FF.
//  3. Keys 1,2,3,4,5 -> full=1, count=4; digits 0..3 show 5,4,3,2 (92,99,B0,A4).
//  4. clr and key_valid(7) in the same cycle with count=2 -> count=0 next cycle, all digits blank, 7 not stored.
//  5. EDIT_EN: keys A,b then F -> count=1, digit0=88; then E -> count=0; then F at count=0 -> no change.
//  6. rst_n low mid-scan with idx=2 and count=3 -> sel=~1, seg=FF, count=0 asynchronously; scan restarts at idx 0.

Source files
------------

// File: rtl/key_disp_pkg.sv
// key_disp_pkg: shared constants and the hex-to-7-segment encoder.
// Used by key_disp_buf. The optional edit keys are enabled with KEY_DISP_EDIT_EN.
package key_disp_pkg;

  // Pattern that turns off every segment, including dp (outputs are active-low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Key codes that become editing commands when KEY_DISP_EDIT_EN is defined.
  localparam logic [3:0] KEY_BKSP  = 4'hF;
  localparam logic [3:0] KEY_CLR   = 4'hE;

  // Convert a hex nibble to an active-low {dp,g,f,e,d,c,b,a} pattern, dp off.
  function automatic logic [7:0] hex2seg(input logic [3:0] code);
    logic [7:0] pat;
    case (code)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/key_disp_buf_scan_tick_gen.sv
// scan_tick_gen: free-running prescaler that counts 0..SCAN_DIV-1 and raises
// tick for the single cycle in which it sits at the wrap value.
module scan_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;

  // Prescaler: wraps to zero after the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/key_disp_buf.sv
// key_disp_buf: keypad entry buffer driving a multiplexed active-low
// 7-segment display. Newest digit sits in entry 0 (rightmost digit).
// Optional feature macro: KEY_DISP_EDIT_EN (F = backspace, E = clear).
module key_disp_buf
  import key_disp_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter int DIGITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   key_num,
  input  logic                         key_valid,
  input  logic                         clr,
  output logic [DIGITS-1:0]            sel,
  output logic [7:0]                   seg,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] digit_buf;
  logic [IW-1:0]          idx;
  logic                   tick;

  scan_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Entry buffer and digit count; clear has priority over a coincident key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_buf <= '0;
      count     <= '0;
    end else if (clr) begin
      digit_buf <= '0;
      count     <= '0;
    end else if (key_valid) begin
`ifdef KEY_DISP_EDIT_EN
      if (key_num == KEY_BKSP) begin
        // Dropping the newest digit pulls older ones toward digit 0.
        if (count != '0) begin
          digit_buf <= {4'h0, digit_buf[DIGITS-1:1]};
          count     <= count - CW'(1);
        end
      end else if (key_num == KEY_CLR) begin
        digit_buf <= '0;
        count     <= '0;
      end else begin
        digit_buf <= {digit_buf[DIGITS-2:0], key_num};
        if (count != CNT_MAX) begin
          count <= count + CW'(1);
        end
      end
`else
      digit_buf <= {digit_buf[DIGITS-2:0], key_num};
      if (count != CNT_MAX) begin
        count <= count + CW'(1);
      end
`endif
    end
  end

  // Scan index advances once per prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // Registered display drive; unentered positions stay blank (no leading zeros).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= ~DIGITS'(1);
      seg <= SEG_BLANK;
    end else begin
      sel <= ~(DIGITS'(1) << idx);
      if (32'(idx) < 32'(count)) begin
        seg <= hex2seg(digit_buf[idx]);
      end else begin
        seg <= SEG_BLANK;
      end
    end
  end

  assign full = (count == CNT_MAX);

endmodule

// File: tb/tb_key_disp_buf.sv
// tb_key_disp_buf: directed self-checking bench for key_disp_buf
// (CLK_HZ=1000, SCAN_HZ=100 -> 10 clocks per digit, DIGITS=4).
module tb_key_disp_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_num = 4'h0;
  logic       key_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sel;
  logic [7:0] seg;
  logic [2:0] count;
  logic       full;

  int n_tests = 0;
  int n_fail  = 0;

  key_disp_buf #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .DIGITS  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_num   (key_num),
    .key_valid (key_valid),
    .clr       (clr),
    .sel       (sel),
    .seg       (seg),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_num   = k;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // Wait (bounded) until digit k is enabled, then check its segment pattern.
  task automatic check_digit(input int k, input logic [7:0] exp, input string tag);
    logic [3:0] want;
    bit         seen;
    want = ~(4'b0001 << k);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (sel === want) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_timeout observed_sel=%h expected_sel=%h", tag, sel, want);
    end else begin
      chk(tag, seg, exp);
    end
  endtask

  initial begin
    // 1. reset state and idle scan
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_sel", {4'h0, sel}, 8'h0E);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_count", {5'h0, count}, 8'h00);
    chk("rst_full", {7'h0, full}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(10);
    chk("scan_e10_sel", {4'h0, sel}, 8'h0E);
    chk("scan_e10_seg", seg, 8'hFF);
    step(1);
    chk("scan_e11_sel", {4'h0, sel}, 8'h0D);
    step(9);
    chk("scan_e20_sel", {4'h0, sel}, 8'h0D);
    chk("scan_e20_seg", seg, 8'hFF);
    step(1);
    chk("scan_e21_sel", {4'h0, sel}, 8'h0B);
    step(10);
    chk("scan_e31_sel", {4'h0, sel}, 8'h07);
    chk("scan_e31_seg", seg, 8'hFF);
    step(10);
    chk("scan_e41_sel", {4'h0, sel}, 8'h0E);
    chk("idle_count", {5'h0, count}, 8'h00);

    // 2. keys 1,2,3 (also confirms one-cycle count latency)
    press(4'h1);
    chk("lat_count", {5'h0, count}, 8'h01);
    press(4'h2);
    press(4'h3);
    chk("k3_count", {5'h0, count}, 8'h03);
    chk("k3_full", {7'h0, full}, 8'h00);
    check_digit(0, 8'hB0, "k3_d0");
    check_digit(1, 8'hA4, "k3_d1");
    check_digit(2, 8'hF9, "k3_d2");
    check_digit(3, 8'hFF, "k3_d3");

    // 3. keys 1..5 back-to-back: overflow drops oldest
    do_clr();
    chk("clr_count", {5'h0, count}, 8'h00);
    for (int k = 1; k <= 5; k++) press(4'(k));
    chk("k5_count", {5'h0, count}, 8'h04);
    chk("k5_full", {7'h0, full}, 8'h01);
    check_digit(0, 8'h92, "k5_d0");
    check_digit(1, 8'h99, "k5_d1");
    check_digit(2, 8'hB0, "k5_d2");
    check_digit(3, 8'hA4, "k5_d3");

    // 4. clr and key in same cycle: clr wins
    do_clr();
    press(4'h8);
    press(4'h9);
    chk("pre_clr_count", {5'h0, count}, 8'h02);
    clr = 1'b1; key_num = 4'h7; key_valid = 1'b1;
    step(1);
    clr = 1'b0; key_valid = 1'b0;
    chk("clrkey_count", {5'h0, count}, 8'h00);
    chk("clrkey_full", {7'h0, full}, 8'h00);
    check_digit(0, 8'hFF, "clrkey_d0");
    check_digit(1, 8'hFF, "clrkey_d1");

    // 5. edit keys (or plain E/F digits in the default build)
    do_clr();
`ifdef KEY_DISP_EDIT_EN
    press(4'hA);
    press(4'hB);
    press(4'hF);
    chk("bksp_count", {5'h0, count}, 8'h01);
    check_digit(0, 8'h88, "bksp_d0");
    check_digit(1, 8'hFF, "bksp_d1");
    press(4'hE);
    chk("eclr_count", {5'h0, count}, 8'h00);
    press(4'hF);
    chk("bksp0_count", {5'h0, count}, 8'h00);
    check_digit(0, 8'hFF, "bksp0_d0");
`else
    press(4'hE);
    press(4'hF);
    chk("ef_count", {5'h0, count}, 8'h02);
    check_digit(0, 8'h8E, "ef_d0");
    check_digit(1, 8'h86, "ef_d1");
    press(4'hC);
    press(4'hD);
    check_digit(0, 8'hA1, "cd_d0");
    check_digit(3, 8'h86, "cd_d3");
`endif

    // 6. async reset mid-scan at idx=2, count=3
    do_clr();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check_digit(2, 8'hF9, "pre_rst_d2");
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", {4'h0, sel}, 8'h0E);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_count", {5'h0, count}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(10);
    chk("restart_e10_sel", {4'h0, sel}, 8'h0E);
    step(1);
    chk("restart_e11_sel", {4'h0, sel}, 8'h0D);
    chk("restart_seg", seg, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
